// File: rtl/apb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module  : apb_gpio_irq
// Brief   : APB GPIO block with synchronised inputs, output/direction
//           registers and per-pin level/edge interrupts with W1C status.
// Revision: 1.0 - initial release
// ============================================================================
module apb_gpio_irq #(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [4:0]            PADDR,
    input  logic [31:0]           PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] GPIO_I,
    output logic [GPIO_WIDTH-1:0] GPIO_O,
    output logic [GPIO_WIDTH-1:0] GPIO_OE,
    output logic                  IRQ_O
);

    localparam logic [2:0] c_IDX_DIN  = 3'd0;
    localparam logic [2:0] c_IDX_DOUT = 3'd1;
    localparam logic [2:0] c_IDX_DIR  = 3'd2;
    localparam logic [2:0] c_IDX_EN   = 3'd3;
    localparam logic [2:0] c_IDX_TYPE = 3'd4;
    localparam logic [2:0] c_IDX_POL  = 3'd5;
    localparam logic [2:0] c_IDX_STAT = 3'd6;
    localparam logic [2:0] c_IDX_BAD  = 3'd7;

    logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] r_dout;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_irq_en;
    logic [GPIO_WIDTH-1:0] r_type;
    logic [GPIO_WIDTH-1:0] r_pol;
    logic [GPIO_WIDTH-1:0] r_stat;
    logic                  r_irq;

    logic                  w_access;
    logic [2:0]            w_idx;
    logic                  w_err;
    logic                  w_wr;
    logic                  w_rd;
    logic [31:0]           w_bmask32;
    logic [GPIO_WIDTH-1:0] w_wmask;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_s;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_edge_hit;
    logic [GPIO_WIDTH-1:0] w_lvl_hit;
    logic [GPIO_WIDTH-1:0] w_set;
    logic [GPIO_WIDTH-1:0] w_clr;
    logic [31:0]           w_rdata;

    // Gating with PRESETn keeps PRDATA/PSLVERR quiet while reset is held.
    assign w_access = PSEL & PENABLE & PRESETn;
    assign w_idx    = PADDR[4:2];
    assign w_err    = w_access & ((PADDR[1:0] != 2'b00) | (w_idx == c_IDX_BAD) |
                                  (PWRITE & (w_idx == c_IDX_DIN)));
    assign w_wr     = w_access & PWRITE & ~w_err;
    assign w_rd     = w_access & ~PWRITE & ~w_err;

    assign w_bmask32 = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign w_wmask   = w_bmask32[GPIO_WIDTH-1:0];
    assign w_wdata   = PWDATA[GPIO_WIDTH-1:0];

    function automatic logic [GPIO_WIDTH-1:0] merge(
        input logic [GPIO_WIDTH-1:0] old_val,
        input logic [GPIO_WIDTH-1:0] new_val,
        input logic [GPIO_WIDTH-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= GPIO_I;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_s;
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_prev;
    assign w_fall     = ~w_s & r_prev;
    assign w_edge_hit = (r_pol & w_rise) | (~r_pol & w_fall);
    assign w_lvl_hit  = (r_pol & w_s) | (~r_pol & ~w_s);
    assign w_set      = r_irq_en & ((r_type & w_edge_hit) | (~r_type & w_lvl_hit));
    assign w_clr      = (w_wr && (w_idx == c_IDX_STAT)) ? (w_wdata & w_wmask) : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_dout   <= '0;
            r_dir    <= '0;
            r_irq_en <= '0;
            r_type   <= '0;
            r_pol    <= '0;
        end else if (w_wr) begin
            case (w_idx)
                c_IDX_DOUT: r_dout   <= merge(r_dout,   w_wdata, w_wmask);
                c_IDX_DIR:  r_dir    <= merge(r_dir,    w_wdata, w_wmask);
                c_IDX_EN:   r_irq_en <= merge(r_irq_en, w_wdata, w_wmask);
                c_IDX_TYPE: r_type   <= merge(r_type,   w_wdata, w_wmask);
                c_IDX_POL:  r_pol    <= merge(r_pol,    w_wdata, w_wmask);
                default: ;
            endcase
        end
    end

    // A set in the same cycle as a W1C wins, so an active level re-asserts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_stat <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_set;
            r_irq  <= |(r_stat & r_irq_en);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_idx)
                c_IDX_DIN:  w_rdata[GPIO_WIDTH-1:0] = w_s;
                c_IDX_DOUT: w_rdata[GPIO_WIDTH-1:0] = r_dout;
                c_IDX_DIR:  w_rdata[GPIO_WIDTH-1:0] = r_dir;
                c_IDX_EN:   w_rdata[GPIO_WIDTH-1:0] = r_irq_en;
                c_IDX_TYPE: w_rdata[GPIO_WIDTH-1:0] = r_type;
                c_IDX_POL:  w_rdata[GPIO_WIDTH-1:0] = r_pol;
                c_IDX_STAT: w_rdata[GPIO_WIDTH-1:0] = r_stat;
                default: ;
            endcase
        end
    end

    assign PRDATA  = w_rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_err;
    assign GPIO_O  = r_dout;
    assign GPIO_OE = r_dir;
    assign IRQ_O   = r_irq;

endmodule
`default_nettype wire

// File: doc/apb_gpio_irq.md
APB_GPIO_IRQ -- requirements
Module: apb_gpio_irq

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 32: pin count; legal values 8, 16, 24 and 32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth; legal values 2 and 3.
REQ-003 SHALL have port PCLK, input, 1: the single clock; all flops on rising edge.
REQ-004 SHALL have port PRESETn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port PSEL, input, 1: APB select.
REQ-006 SHALL have port PENABLE, input, 1: APB access phase.
REQ-007 SHALL have port PWRITE, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port PADDR, input, 5: byte address.
REQ-009 SHALL have port PWDATA, input, 32: write data.
REQ-010 SHALL have port PSTRB, input, 4: byte-lane write strobes.
REQ-011 SHALL have port PRDATA, output, 32: read data.
REQ-012 SHALL have port PREADY, output, 1: transfer ready.
REQ-013 SHALL have port PSLVERR, output, 1: transfer error.
REQ-014 SHALL have port GPIO_I, input, GPIO_WIDTH: pad inputs, asynchronous to PCLK.
REQ-015 SHALL have port GPIO_O, output, GPIO_WIDTH: pad output data.
REQ-016 SHALL have port GPIO_OE, output, GPIO_WIDTH: pad output enable, 1 = drive.
REQ-017 SHALL have port IRQ_O, output, 1: interrupt, active-high, registered.

Function
REQ-018 Register map (word offsets): 0x00 DATA_IN (RO), 0x04 DATA_OUT (RW), 0x08 DIR (RW), 0x0C IRQ_EN (RW), 0x10 IRQ_TYPE (RW; 0 = level, 1 = edge), 0x14 IRQ_POL (RW; 0 = low/falling, 1 = high/rising), 0x18 IRQ_STATUS (RW1C).
REQ-019 PREADY SHALL be constant 1; every transfer completes in its access cycle (PSEL & PENABLE).
REQ-020 Any of these errors SHALL assert PSLVERR only in the access cycle and leave all state unchanged: PADDR[1:0] != 0, offset > 0x18, or a write to 0x00.
REQ-021 Writes SHALL update only byte lanes with PSTRB[n]=1, and only at the access-cycle rising edge.
REQ-022 Register bits at or above GPIO_WIDTH SHALL not exist; they SHALL read as 0 and ignore writes.
REQ-023 PRDATA SHALL be the addressed register during a valid read access cycle, and 0 otherwise, including on error.
REQ-024 GPIO_I SHALL pass through a SYNC_STAGES flop chain whose output is s; DATA_IN SHALL read s.
REQ-025 A flop p SHALL hold the previous s; rise = s & ~p; fall = ~s & p.
REQ-026 Per bit, when IRQ_EN=1, the set condition SHALL be:
- edge mode: (POL ? rise : fall);
- level mode: (POL ? s : ~s).
REQ-027 IRQ_STATUS bits SHALL be sticky and cleared by writing 1 with the lane strobe set; set SHALL win over a same-cycle clear.
REQ-028 In level mode, a bit cleared while its level is still active SHALL re-set on the next edge.
REQ-029 Clearing IRQ_EN SHALL NOT clear IRQ_STATUS; IRQ_O SHALL register |(IRQ_STATUS & IRQ_EN).
REQ-030 Latency, SYNC_STAGES=2, GPIO_I stable before edge 1:
- s = 1 after edge 2;
- IRQ_STATUS sets at edge 3;
- IRQ_O rises at edge 4.
REQ-031 GPIO_O SHALL equal DATA_OUT and GPIO_OE SHALL equal DIR, both directly from flops.
REQ-032 A reconfigured IRQ_TYPE or IRQ_POL SHALL take effect on the cycle after the write.

Reset
REQ-033 PRESETn low SHALL immediately (asynchronously) zero every register, sync flop and p: GPIO_O=0, GPIO_OE=0, IRQ_O=0.
REQ-034 During reset PRDATA=0, PSLVERR=0, PREADY=1.
REQ-035 Reset release SHALL be handled as synchronous de-assertion by the system.
REQ-036 An APB transfer in progress when reset asserts SHALL be discarded.
REQ-037 A spurious rise after reset SHALL set no status, because IRQ_EN=0.

Verification
REQ-038 Write 0x04=0xA5A5_A5A5 with PSTRB=0011, then 0x08=0xFFFF_FFFF -> read 0x04 = 0x0000_A5A5; GPIO_O=0x0000_A5A5; GPIO_OE all 1.
REQ-039 Drive GPIO_I=0x0000_0F00 -> read 0x00 returns 0x0000_0F00, 2 cycles later at SYNC_STAGES=2.
REQ-040 IRQ_EN[3]=1, TYPE[3]=1, POL[3]=1, GPIO_I[3] 0->1 -> STATUS=0x8 at edge 3, IRQ_O=1 at edge 4; write 0x18=0x8 -> IRQ_O=0 two cycles later.
REQ-041 Level-high on bit 0, pin held high, W1C bit 0 -> status re-sets the next cycle and IRQ_O stays 1; pin low then W1C -> IRQ_O=0.
REQ-042 Read 0x1C, read 0x05, write 0x00 -> PSLVERR=1 for one cycle each; PRDATA=0; no register changes.
REQ-043 Assert PRESETn mid-write with IRQ_O=1 -> all outputs 0 immediately; all registers read 0 after release.
